// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers, bursts of <= MAX_BURST.
// Define FIFO_ARB_ID_TAG_EN to prepend the owner ID to each written word: {owner_id, payload}.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*WIDTH-1:0]         req_data,
    output logic [N_REQ-1:0]               ack,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
`ifdef FIFO_ARB_ID_TAG_EN
    output logic [WIDTH+$clog2(N_REQ)-1:0] fifo_wr_data,
`else
    output logic [WIDTH-1:0]               fifo_wr_data,
`endif
    output logic [$clog2(N_REQ)-1:0]       owner_id,
    output logic                           burst_active
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {StIdle, StBurst} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  beat_next;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   cand;
    logic              owner_req;
    logic [WIDTH-1:0]  owner_data;
    logic              wr_en;

    // Modulo-N_REQ increment; also correct when N_REQ is not a power of two.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!grant_found && cand == ID_W'(j) && req[j]) begin
                    grant_found = 1'b1;
                    grant_id    = cand;
                end
            end
            cand = next_id(cand);
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (owner_q == ID_W'(j)) begin
                owner_req  = req[j];
                owner_data = req_data[j*WIDTH +: WIDTH];
            end
        end
    end

    assign wr_en     = (state_q == StBurst) && owner_req && !fifo_full;
    assign beat_next = beat_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    owner_d    = grant_id;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                // A dropped request ends the burst even while the FIFO is full.
                if (!owner_req) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_id(owner_q);
                end else if (wr_en) begin
                    beat_cnt_d = beat_next;
                    if (beat_next == CNT_W'(MAX_BURST)) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_id(owner_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack = '0;
        for (int j = 0; j < N_REQ; j++) begin
            ack[j] = wr_en && (owner_q == ID_W'(j));
        end
    end

    assign fifo_wr_en   = wr_en;
    assign owner_id     = owner_q;
    assign burst_active = (state_q == StBurst);

`ifdef FIFO_ARB_ID_TAG_EN
    assign fifo_wr_data = wr_en ? {owner_q, owner_data} : '0;
`else
    assign fifo_wr_data = wr_en ? owner_data : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a behavioural round-robin/burst model.
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = $clog2(N_REQ);
`ifdef FIFO_ARB_ID_TAG_EN
    localparam int DW = WIDTH + ID_W;
`else
    localparam int DW = WIDTH;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [DW-1:0]          fifo_wr_data;
    logic [ID_W-1:0]        owner_id;
    logic                   burst_active;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .owner_id     (owner_id),
        .burst_active (burst_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_writes = 0;
    int w0;

    // Per-requester payload; a requester advances its data when its beat is accepted.
    logic [WIDTH-1:0] d [N_REQ];

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = d[i];
    end

    // Reference model: busy flag, owner, beats written in this burst, round-robin pointer.
    bit m_busy;
    int m_owner, m_beats, m_ptr;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic step();
        logic             exp_wr;
        logic [31:0]      exp_ack;
        logic [31:0]      exp_data;
        logic [WIDTH-1:0] pay;
        bit               found;
        int               idx;
        #1;
        pay      = d[ID_W'(m_owner)];
        exp_wr   = !rst && m_busy && req[ID_W'(m_owner)] && !fifo_full;
        exp_ack  = exp_wr ? (32'd1 << m_owner) : 32'd0;
        exp_data = 32'd0;
`ifdef FIFO_ARB_ID_TAG_EN
        if (exp_wr) exp_data = (32'(m_owner) << WIDTH) | 32'(pay);
`else
        if (exp_wr) exp_data = 32'(pay);
`endif
        check("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        check("ack", 32'(ack), exp_ack);
        check("wr_data", 32'(fifo_wr_data), exp_data);
        check("owner_id", 32'(owner_id), 32'(m_owner));
        check("burst_active", 32'(burst_active), 32'(m_busy));
        check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        if (fifo_wr_en) dut_writes++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (!found && req[ID_W'(idx)]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = idx;
                    m_beats = 0;
                end
            end
        end else if (!req[ID_W'(m_owner)]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N_REQ;
        end else if (!fifo_full) begin
            d[ID_W'(m_owner)] = d[ID_W'(m_owner)] + 8'd1;
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N_REQ;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [N_REQ-1:0] r, input logic full, input int n);
        req       = r;
        fifo_full = full;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N_REQ; i++) d[i] = 8'($urandom);
        model_reset();
        @(negedge clk);
        step();                                   // outputs held at zero in reset
        rst = 1'b0;
        drive(4'b0000, 1'b0, 2);

        // Single requester 1: three beats A1..A3, then request drops.
        d[1] = 8'hA1;
        w0 = dut_writes;
        drive(4'b0010, 1'b0, 4);
        drive(4'b0000, 1'b0, 1);
        check("t1_beats", 32'(dut_writes - w0), 32'd3);
        check("t1_owner", 32'(owner_id), 32'd1);
        drive(4'b0000, 1'b0, 1);

        // All requesting: pointer is at 2, so grants 2,3,0,1,2 with full bursts and bubbles.
        drive(4'b1111, 1'b0, 25);
        drive(4'b0000, 1'b0, 2);

        // Requester 2 burst, FIFO full for 3 cycles after beat 2: still 4 beats in total.
        w0 = dut_writes;
        drive(4'b0100, 1'b0, 3);                 // grant + 2 beats
        drive(4'b0100, 1'b1, 3);
        check("t3_stall_owner", 32'(owner_id), 32'd2);
        drive(4'b0100, 1'b0, 3);
        check("t3_beats", 32'(dut_writes - w0), 32'd4);
        drive(4'b0000, 1'b0, 2);

        // Requester 0 drops after 2 beats while 3 waits; pointer is at 3 after test 3, so
        // route through 3 first to bring the pointer to 0.
        drive(4'b1000, 1'b0, 1);
        drive(4'b0000, 1'b0, 2);
        drive(4'b1001, 1'b0, 3);
        check("t4_owner0", 32'(owner_id), 32'd0);
        drive(4'b1000, 1'b0, 2);
        check("t4_owner3", 32'(owner_id), 32'd3);
        drive(4'b0000, 1'b0, 5);

        // Tag/payload check for requester 2 with data 5A.
        d[2] = 8'h5A;
        drive(4'b0100, 1'b0, 1);
        #1;
`ifdef FIFO_ARB_ID_TAG_EN
        check("t6_tagged", 32'(fifo_wr_data), 32'h25A);
`else
        check("t6_plain", 32'(fifo_wr_data), 32'h5A);
`endif
        drive(4'b0100, 1'b0, 1);
        drive(4'b0000, 1'b0, 2);

        // Reset mid-burst at beat 2: outputs drop immediately, search restarts from 0.
        drive(4'b0010, 1'b0, 3);
        #2 rst = 1'b1;
        #1;
        check("t5_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_burst", 32'(burst_active), 32'd0);
        model_reset();
        @(negedge clk);
        drive(4'b1111, 1'b0, 1);
        rst = 1'b0;
        drive(4'b1111, 1'b0, 2);
        check("t5_regrant", 32'(owner_id), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N_REQ-1:0] r;
            for (int i = 0; i < N_REQ; i++) r[i] = ($urandom_range(0, 9) < 7);
            drive(r, ($urandom_range(0, 4) == 0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
